// File: rtl/fetch_queue_if.sv
// Decode-side handshake of the fetch queue.
// Head entry {Instr, Instr_PC} offered under valid/ready.
interface fetch_queue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] Instr;
  logic [ADDR_W-1:0]  Instr_PC;
  logic               Instr_Valid;
  logic               Instr_Ready;

  modport master (
    output Instr,
    output Instr_PC,
    output Instr_Valid,
    input  Instr_Ready
  );

  modport slave (
    input  Instr,
    input  Instr_PC,
    input  Instr_Valid,
    output Instr_Ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: issues PCs to a synchronous ROM and queues
// returned words with their PCs in a show-ahead prefetch FIFO.
module fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  PC,
  input  logic               Flush,
  output logic               Enable_PC,
  output logic [ADDR_W-1:0]  Imem_Addr,
  input  logic [INSTR_W-1:0] Imem_Data,
  fetch_queue_if.master      dec
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  logic [CW:0] occ;
  logic        issue;
  logic        push;
  logic        pop;

  // Credit counts the outstanding fetch but not a same-cycle pop,
  // which keeps Instr_Ready out of the Enable_PC path.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = !Reset && !Flush && (occ < DEPTH_C);
  assign push  = inflight && !Flush;
  assign pop   = dec.Instr_Valid && dec.Instr_Ready && !Flush;

  assign Enable_PC       = issue;
  assign Imem_Addr       = PC;
  assign dec.Instr_Valid = (count != '0);
  assign dec.Instr       = instr_mem[rd_ptr];
  assign dec.Instr_PC    = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (Flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= Imem_Data;
        pc_mem[wr_ptr]    <= inflight_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      inflight <= issue;
      if (issue)
        inflight_pc <= PC;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC register and ROM modelled here,
// outputs checked against a queue-level reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic [7:0]  pc = 8'd0;
  logic [7:0]  Imem_Addr;
  logic        Enable_PC;
  logic [15:0] Imem_Data = 16'd0;

  fetch_queue_if #(.ADDR_W(8), .INSTR_W(16)) fq ();

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .PC        (pc),
    .Flush     (Flush),
    .Enable_PC (Enable_PC),
    .Imem_Addr (Imem_Addr),
    .Imem_Data (Imem_Data),
    .dec       (fq)
  );

  logic [15:0] rom [256];
  logic [7:0]  mq [$];
  bit          pend;
  logic [7:0]  pend_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend = 1'b0;
  endtask

  // One clock: drive at negedge, check, then advance env and model.
  task automatic cycle(bit rdy, bit fl, logic [7:0] npc);
    bit         ev;
    bit         een;
    bit         en;
    logic [7:0] a;
    fq.Instr_Ready = rdy;
    Flush = fl;
    #1;
    ev  = (mq.size() != 0);
    een = !fl && ((mq.size() + int'(pend)) < DEPTH);
    chk("valid", 32'(fq.Instr_Valid), 32'(ev));
    chk("enable_pc", 32'(Enable_PC), 32'(een));
    chk("imem_addr", 32'(Imem_Addr), 32'(pc));
    if (ev) begin
      chk("instr_pc", 32'(fq.Instr_PC), 32'(mq[0]));
      chk("instr", 32'(fq.Instr), 32'(rom[mq[0]]));
    end
    a  = Imem_Addr;
    en = Enable_PC;
    if (fl) begin
      model_clear();
    end else begin
      if (pend) begin
        chk("no_push_full", 32'(mq.size() < DEPTH), 32'd1);
        mq.push_back(pend_pc);
      end
      if (ev && rdy)
        void'(mq.pop_front());
      pend    = een;
      pend_pc = pc;
    end
    @(posedge clk);
    #1;
    Imem_Data = rom[a];
    pc = fl ? npc : (en ? pc + 8'd1 : pc);
    @(negedge clk);
  endtask

  task automatic do_reset(logic [7:0] start);
    Reset = 1'b1;
    Flush = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(fq.Instr_Valid), 32'd0);
    pc = start;
    Reset = 1'b0;
    model_clear();
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = 16'($urandom);
    fq.Instr_Ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid0", 32'(fq.Instr_Valid), 32'd0);
    chk("rst_instr0", 32'(fq.Instr), 32'd0);
    chk("rst_instr_pc0", 32'(fq.Instr_PC), 32'd0);
    Reset = 1'b0;

    // streaming with decode always ready
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'd0);

    // backpressure fills the queue, then drain
    do_reset(8'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 8'd0);
    chk("pc_hold", 32'(pc), 32'd4);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'd0);

    // flush with 3 queued and one fetch outstanding
    do_reset(8'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 8'h40);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'd0);

    // pop and return together near full, across pointer wrap
    do_reset(8'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'd0);

    // asynchronous reset between edges
    do_reset(8'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'd0);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(fq.Instr_Valid), 32'd0);
    chk("async_rst_instr_pc", 32'(fq.Instr_PC), 32'd0);
    @(negedge clk);
    pc = 8'h80;
    Reset = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'd0);

    // flush and pop in the same cycle
    do_reset(8'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 8'h10);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'd0);

    // random traffic
    do_reset(8'($urandom));
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
